// File: rtl/vga_pkg.sv
// vga_pkg: pattern mode encodings, 640x480@60 timing defaults and the colour-bar lookup
package vga_pkg;
  typedef enum logic [1:0] {MODE_SOLID, MODE_BARS, MODE_CHECK, MODE_SCROLL} mode_e;
  localparam int DEF_CLK_DIV  = 4;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  // {R,G,B} on/off per bar: white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [2:0] BAR_LUT [8] = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};
  function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
    return BAR_LUT[idx];
  endfunction
endpackage

// File: rtl/vga_pattern_gen_if.sv
// vga_pattern_gen_if: pattern controls in, sync/pixel stream out
interface vga_pattern_gen_if #(parameter int RGB_W = 12, parameter int XW = 10, parameter int YW = 10);
  logic [1:0]       mode;
  logic [RGB_W-1:0] color_sw;
  logic             hsync;
  logic             vsync;
  logic             video_on;
  logic             p_tick;
  logic [XW-1:0]    x;
  logic [YW-1:0]    y;
  logic             frame_start;
  logic [RGB_W-1:0] rgb;
  modport master(output mode, color_sw, input hsync, vsync, video_on, p_tick, x, y, frame_start, rgb);
  modport slave(input mode, color_sw, output hsync, vsync, video_on, p_tick, x, y, frame_start, rgb);
endinterface

// File: rtl/vga_timing_core.sv
// vga_timing_core: pixel-tick divider, h/v counters, frame event and sync/visible decode
module vga_timing_core #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int XW       = 10,
  parameter int YW       = 10
) (
  input  logic          clk,
  input  logic          reset,
  output logic          o_p_tick,
  output logic          o_frame,
  output logic          o_vis,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic [XW-1:0] o_h,
  output logic [YW-1:0] o_v
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [DW-1:0] r_div;
  logic          r_run;
  logic [XW-1:0] r_h;
  logic [YW-1:0] r_v;
  logic          w_h_end;
  logic          w_v_end;
  // r_run keeps p_tick low during reset even when CLK_DIV=1
  assign o_p_tick = r_run && r_div == DW'(CLK_DIV - 1);
  assign w_h_end = r_h == XW'(H_TOTAL - 1);
  assign w_v_end = r_v == YW'(V_TOTAL - 1);
  assign o_frame = o_p_tick && w_h_end && w_v_end;
  assign o_vis = 32'(r_h) < H_ACTIVE && 32'(r_v) < V_ACTIVE;
  assign o_hsync = !(32'(r_h) >= H_ACTIVE + H_FP && 32'(r_h) < H_ACTIVE + H_FP + H_SYNC);
  assign o_vsync = !(32'(r_v) >= V_ACTIVE + V_FP && 32'(r_v) < V_ACTIVE + V_FP + V_SYNC);
  assign o_h = r_h;
  assign o_v = r_v;
  always_ff @(posedge clk)
    if (!reset) begin
      r_div <= '0;
      r_run <= 1'b0;
      r_h   <= '0;
      r_v   <= '0;
    end else begin
      r_run <= 1'b1;
      r_div <= r_div == DW'(CLK_DIV - 1) ? '0 : r_div + 1'b1;
      if (o_p_tick) begin
        r_h <= w_h_end ? '0 : r_h + 1'b1;
        if (w_h_end) r_v <= w_v_end ? '0 : r_v + 1'b1;
      end
    end
endmodule

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: VGA test-pattern generator with frame-latched mode/colour and registered outputs.
// Define VGA_PATTERN_BORDER_EN to force a white one-pixel border around the visible area.
module vga_pattern_gen import vga_pkg::*; #(
  parameter int RGB_W      = 12,
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter int CHECK_LOG2 = 5,
  parameter int BAR_W      = 16
) (
  input logic              clk,
  input logic              reset,
  vga_pattern_gen_if.slave bus
);
  localparam int XW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int YW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam int C  = RGB_W / 3;
  logic             w_p_tick;
  logic             w_frame;
  logic             w_vis;
  logic             w_hs;
  logic             w_vs;
  logic [XW-1:0]    w_h;
  logic [YW-1:0]    w_v;
  logic [2:0]       w_lut;
  logic [RGB_W-1:0] w_bars;
  logic [RGB_W-1:0] w_pat;
  logic [RGB_W-1:0] w_pix;
  mode_e            r_mode;
  logic [RGB_W-1:0] r_color;
  logic [XW-1:0]    r_scroll;
  logic [RGB_W-1:0] r_rgb;
  logic             r_hs;
  logic             r_vs;
  logic             r_von;
  logic             r_fs;
  vga_timing_core #(
    .CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .XW(XW), .YW(YW)
  ) u_core (
    .clk(clk), .reset(reset), .o_p_tick(w_p_tick), .o_frame(w_frame), .o_vis(w_vis),
    .o_hsync(w_hs), .o_vsync(w_vs), .o_h(w_h), .o_v(w_v)
  );
  assign w_lut = bar_rgb(3'(32'(w_h) / (H_ACTIVE / 8)));
  assign w_bars = {{C{w_lut[2]}}, {C{w_lut[1]}}, {C{w_lut[0]}}};
  always_comb begin
    w_pat = r_mode == MODE_SOLID ? r_color :
            r_mode == MODE_BARS  ? w_bars :
            r_mode == MODE_CHECK ? ((w_h[CHECK_LOG2] ^ w_v[CHECK_LOG2]) ? r_color : '0) :
            ((32'(w_h) >= 32'(r_scroll) && 32'(w_h) < 32'(r_scroll) + BAR_W) ? r_color : '0);
  end
`ifdef VGA_PATTERN_BORDER_EN
  assign w_pix = (w_h == '0 || w_h == XW'(H_ACTIVE - 1) || w_v == '0 || w_v == YW'(V_ACTIVE - 1)) ? '1 : w_pat;
`else
  assign w_pix = w_pat;
`endif
  // shadow registers only move on the frame event so a frame never mixes two settings
  always_ff @(posedge clk)
    if (!reset) begin
      r_mode   <= MODE_SOLID;
      r_color  <= '0;
      r_scroll <= '0;
      r_rgb    <= '0;
      r_hs     <= 1'b1;
      r_vs     <= 1'b1;
      r_von    <= 1'b0;
      r_fs     <= 1'b0;
    end else begin
      r_fs <= w_frame;
      if (w_frame) begin
        r_mode   <= mode_e'(bus.mode);
        r_color  <= bus.color_sw;
        r_scroll <= r_scroll == XW'(H_ACTIVE - 1) ? '0 : r_scroll + 1'b1;
      end
      if (w_p_tick) begin
        r_von <= w_vis;
        r_rgb <= w_vis ? w_pix : '0;
        r_hs  <= w_hs;
        r_vs  <= w_vs;
      end
    end
  assign bus.hsync       = r_hs;
  assign bus.vsync       = r_vs;
  assign bus.video_on    = r_von;
  assign bus.rgb         = r_rgb;
  assign bus.frame_start = r_fs;
  assign bus.p_tick      = w_p_tick;
  assign bus.x           = w_h;
  assign bus.y           = w_v;
endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen: randomized self-checking bench on a shrunken raster against a pixel-index reference model
module tb_vga_pattern_gen;
  localparam int CD = 3, HA = 16, HFP = 2, HS = 4, HBP = 2, VA = 8, VFP = 1, VS = 2, VBP = 1, CL = 2, BW = 4;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;
  localparam int XW = $clog2(HT);
  localparam int YW = $clog2(VT);
  localparam int VW = 5 + XW + YW + 12;
`ifdef VGA_PATTERN_BORDER_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif
  localparam logic [11:0] BARS [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
  logic clk = 1'b0;
  logic reset = 1'b0;
  int tests = 0;
  int fails = 0;
  logic [11:0] line_buf [0:HA];
  always #5 clk = ~clk;
  vga_pattern_gen_if #(.RGB_W(12), .XW(XW), .YW(YW)) vif();
  vga_pattern_gen #(
    .RGB_W(12), .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .CHECK_LOG2(CL), .BAR_W(BW)
  ) dut (.clk(clk), .reset(reset), .bus(vif));

  function automatic logic [11:0] ref_pix(int h, int v, int m, logic [11:0] col, int sc);
    if (BORDER && (h == 0 || h == HA - 1 || v == 0 || v == VA - 1)) return 12'hFFF;
    case (m)
      0: return col;
      1: return BARS[h / (HA / 8)];
      2: return (((h >> CL) + (v >> CL)) % 2 == 1) ? col : 12'h000;
      default: return (h >= sc && h < sc + BW) ? col : 12'h000;
    endcase
  endfunction

  // model: clocks since reset release, latched mode/colour, frames elapsed
  bit m_valid = 1'b0;
  bit m_inrst;
  int m_c, m_mode, m_frames;
  logic [11:0] m_col;
  always @(posedge clk)
    if (!reset) begin
      m_valid <= 1'b1; m_inrst <= 1'b1; m_c <= 0; m_mode <= 0; m_col <= '0; m_frames <= 0;
    end else if (m_valid) begin
      m_inrst <= 1'b0;
      m_c <= m_c + 1;
      if ((m_c + 1) % CD == 0 && ((m_c + 1) / CD) % FRAME == 0) begin
        m_mode <= int'(vif.mode); m_col <= vif.color_sw; m_frames <= m_frames + 1;
      end
    end

  always @(negedge clk)
    if (m_valid) begin : chk
      int k, p, ph, pv;
      logic vis;
      logic [VW-1:0] e, a;
      k = m_c / CD; p = k - 1; ph = p % HT; pv = (p / HT) % VT;
      vis = k > 0 && ph < HA && pv < VA;
      e = {!(k > 0 && ph >= HA + HFP && ph < HA + HFP + HS), !(k > 0 && pv >= VA + VFP && pv < VA + VFP + VS),
           vis, !m_inrst && (m_c + 1) % CD == 0, m_c > 0 && m_c % CD == 0 && k % FRAME == 0,
           XW'(k % HT), YW'((k / HT) % VT), vis ? ref_pix(ph, pv, m_mode, m_col, m_frames % HA) : 12'h000};
      a = {vif.hsync, vif.vsync, vif.video_on, vif.p_tick, vif.frame_start, vif.x, vif.y, vif.rgb};
      tests++;
      if (a !== e) begin
        fails++;
        if (fails < 40) $display("FAIL model c=%0d {hs,vs,von,pt,fs,x,y,rgb} got %h want %h", m_c, a, e);
      end
    end

  task automatic wait_fs(string tag);
    for (int i = 0; i < 2 * FRAME * CD + 10; i++) begin
      @(negedge clk);
      if (vif.frame_start) break;
    end
    tests++;
    if (!vif.frame_start) begin fails++; $display("FAIL %s frame_start timeout got 0 want 1", tag); end
  endtask

  // call right after a frame_start negedge; pixel j is on the outputs at the (j+1)th p_tick sample
  task automatic cap_line(input int vl);
    int n = 0;
    int j;
    for (int i = 0; i < FRAME * CD; i++) begin
      @(negedge clk);
      if (vif.p_tick) begin
        j = n - 1;
        if (n > 0 && j / HT == vl && j % HT <= HA) line_buf[j % HT] = vif.rgb;
        n++;
        if (j >= vl * HT + HA) break;
      end
    end
  endtask

  task automatic test_reset();
    int first = 0;
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      tests++;
      if ({vif.hsync, vif.vsync, vif.rgb} !== {2'b11, 12'h000}) begin
        fails++; $display("FAIL reset_hold {hs,vs,rgb} got %h want %h", {vif.hsync, vif.vsync, vif.rgb}, {2'b11, 12'h000});
      end
    end
    reset = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (vif.p_tick) begin first = i + 1; break; end
    end
    tests++;
    if (first != CD) begin fails++; $display("FAIL first_ptick clk got %0d want %0d", first, CD); end
  endtask

  task automatic test_timing();
    int hl = 0, vl = 0, von = 0;
    wait_fs("timing");
    for (int i = 0; i < FRAME * CD; i++) begin
      @(negedge clk);
      if (vif.p_tick) begin
        hl += int'(!vif.hsync); vl += int'(!vif.vsync); von += int'(vif.video_on);
      end
    end
    tests += 3;
    if (hl != HS * VT) begin fails++; $display("FAIL hsync_low got %0d want %0d", hl, HS * VT); end
    if (vl != VS * HT) begin fails++; $display("FAIL vsync_low got %0d want %0d", vl, VS * HT); end
    if (von != HA * VA) begin fails++; $display("FAIL video_on got %0d want %0d", von, HA * VA); end
  endtask

  task automatic test_solid_latch();
    int bad = 0, cnt = 0, blank = 0;
    bit seen = 0;
    @(negedge clk); vif.mode = 2'd0; vif.color_sw = 12'h123;
    wait_fs("solid_a");
    wait_fs("solid_b");
    repeat (FRAME * CD / 2) @(negedge clk);
    vif.color_sw = 12'hF00;
    for (int i = 0; i < FRAME * CD; i++) begin
      @(negedge clk);
      if (vif.frame_start) begin seen = 1; break; end
      if (vif.rgb == 12'hF00) bad++;
    end
    tests += 2;
    if (!seen) begin fails++; $display("FAIL solid_fs got 0 want 1"); end
    if (bad != 0) begin fails++; $display("FAIL solid_early F00 pixels got %0d want 0", bad); end
    for (int i = 0; i < FRAME * CD; i++) begin
      @(negedge clk);
      if (vif.p_tick) begin
        if (vif.video_on && vif.rgb == 12'hF00) cnt++;
        if (!vif.video_on && vif.rgb != 12'h000) blank++;
      end
    end
    tests += 2;
    if (cnt != (BORDER ? (HA - 2) * (VA - 2) : HA * VA)) begin
      fails++; $display("FAIL solid_count got %0d want %0d", cnt, BORDER ? (HA - 2) * (VA - 2) : HA * VA);
    end
    if (blank != 0) begin fails++; $display("FAIL solid_blank nonzero got %0d want 0", blank); end
  endtask

  task automatic test_bars();
    logic [11:0] exp;
    @(negedge clk); vif.mode = 2'd1;
    wait_fs("bars");
    cap_line(1);
    for (int h = 0; h <= HA; h++) begin
      exp = h == HA ? 12'h000 : (BORDER && (h == 0 || h == HA - 1)) ? 12'hFFF : BARS[h / (HA / 8)];
      tests++;
      if (line_buf[h] !== exp) begin fails++; $display("FAIL bars h=%0d got %h want %h", h, line_buf[h], exp); end
    end
  endtask

  task automatic test_scroll();
    int s, w, first, ew, ef;
    @(negedge clk); vif.mode = 2'd3; vif.color_sw = 12'h0F0;
    wait_fs("scroll_latch");
    for (int f = 0; f < HA + 2; f++) begin
      s = m_frames % HA;
      cap_line(1);
      w = 0; first = -1; ew = 0; ef = -1;
      for (int h = 0; h < HA; h++) begin
        if (line_buf[h] === 12'h0F0) begin w++; if (first < 0) first = h; end
        if (h >= s && h < s + BW && !(BORDER && (h == 0 || h == HA - 1))) begin ew++; if (ef < 0) ef = h; end
      end
      tests += 2;
      if (w != ew) begin fails++; $display("FAIL scroll_width s=%0d got %0d want %0d", s, w, ew); end
      if (first != ef) begin fails++; $display("FAIL scroll_start s=%0d got %0d want %0d", s, first, ef); end
      wait_fs("scroll_next");
    end
  endtask

  task automatic test_reset_midframe();
    bit hit = 0;
    logic [11:0] col, exp;
    for (int i = 0; i < 2 * FRAME * CD; i++) begin
      @(negedge clk);
      if (vif.x == XW'(10) && vif.y == YW'(5)) begin hit = 1; break; end
    end
    tests++;
    if (!hit) begin fails++; $display("FAIL mid_reach got 0 want 1"); end
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if ({vif.x, vif.y, vif.hsync, vif.vsync, vif.video_on, vif.rgb, vif.p_tick, vif.frame_start} !==
        {{XW{1'b0}}, {YW{1'b0}}, 2'b11, 1'b0, 12'h000, 2'b00}) begin
      fails++;
      $display("FAIL mid_reset {x,y,hs,vs,von,rgb,pt,fs} got %h want %h",
        {vif.x, vif.y, vif.hsync, vif.vsync, vif.video_on, vif.rgb, vif.p_tick, vif.frame_start},
        {{XW{1'b0}}, {YW{1'b0}}, 2'b11, 1'b0, 12'h000, 2'b00});
    end
    reset = 1'b1;
    for (int m = 0; m < 4; m++) begin
      col = 12'($urandom);
      @(negedge clk); vif.mode = 2'(m); vif.color_sw = col;
      wait_fs("origin");
      cap_line(0);
      exp = BORDER ? 12'hFFF : ref_pix(0, 0, m, col, m_frames % HA);
      tests++;
      if (line_buf[0] !== exp) begin fails++; $display("FAIL origin mode=%0d got %h want %h", m, line_buf[0], exp); end
    end
  endtask

  task automatic test_random();
    int fs = 0;
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(1, FRAME * CD)) @(negedge clk);
      vif.mode = 2'($urandom); vif.color_sw = 12'($urandom);
    end
    for (int i = 0; i < 2 * FRAME * CD; i++) begin
      @(negedge clk);
      fs += int'(vif.frame_start);
    end
    tests++;
    if (fs != 2) begin fails++; $display("FAIL frame_pulses got %0d want 2", fs); end
  endtask

  initial begin
    vif.mode = 2'd0;
    vif.color_sw = 12'h000;
    test_reset();
    test_timing();
    test_solid_latch();
    test_bars();
    test_scroll();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
